// File: rtl/store_buffer_if.sv
// Backing-memory side of the store buffer: head-entry request/ack handshake
// plus the combinational read-data return used when a load misses the buffer.
interface store_buffer_if #(
  parameter int AW = 32
);
  logic          MemReq;
  logic [AW-1:0] MemAdr;
  logic [AW-1:0] MemWData;
  logic          MemAck;
  logic [AW-1:0] MemRData;

  // The store buffer drives the request toward memory.
  modport master (
    output MemReq,
    output MemAdr,
    output MemWData,
    input  MemAck,
    input  MemRData
  );

  // The backing memory answers the request and supplies load data.
  modport slave (
    input  MemReq,
    input  MemAdr,
    input  MemWData,
    output MemAck,
    output MemRData
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a slower data memory.
// Stores are queued in a FIFO and drained in order over req/ack. Loads see
// the youngest buffered store to the same word. The core is stalled only
// when a store arrives while the FIFO is full.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [AW-1:0]              DataAdr,
  input  logic [AW-1:0]              WriteData,
  output logic [AW-1:0]              ReadData,
  output logic                       Stall,
  store_buffer_if.master             mem,
  output logic [$clog2(DEPTH):0]     Level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] adr_q  [DEPTH];
  logic [AW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  logic [AW-1:0] fwd_data;
  logic [PW-1:0] scan_idx;

  // Occupancy flags and the push/pop qualifiers.
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    push  = MemWrite & ~full;
    pop   = ~empty & mem.MemAck;
    Stall = MemWrite & full;
  end

  // Head entry is presented to memory straight from storage.
  always_comb begin
    mem.MemReq   = ~empty;
    mem.MemAdr   = adr_q[head];
    mem.MemWData = data_q[head];
  end

  // Entry storage: written at the tail on push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail]  <= DataAdr;
      data_q[tail] <= WriteData;
    end
  end

  // Pointer and occupancy update; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word-granular load forwarding. Entries are walked oldest (head) to
  // youngest (tail-1) so a later match overrides an earlier one; walking by
  // age offset from head handles the pointer wrap without special cases.
  always_comb begin
    fwd_data = mem.MemRData;
    scan_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if ((CW'(k) < count) &&
          (DataAdr[AW-1:2] == adr_q[scan_idx][AW-1:2])) begin
        fwd_data = data_q[scan_idx];
      end
    end
    ReadData = fwd_data;
  end

  // Occupancy is reported directly from the registered count.
  always_comb begin
    Level = count;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4, AW=32). Inputs change 1 time
// unit after a rising edge; combinational outputs are checked once settled.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic [2:0]  Level;

  int tests;
  int fails;

  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  int          base;

  store_buffer_if #(.AW(32)) mif ();

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem       (mif.master),
    .Level     (Level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing-memory observer: records every accepted head entry in order.
  always @(posedge clk) begin
    if (!reset && mif.MemReq && mif.MemAck) begin
      log_adr.push_back(mif.MemAdr);
      log_dat.push_back(mif.MemWData);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    MemWrite = 1'b0;
    DataAdr = '0;
    WriteData = '0;
    mif.MemAck = 1'b0;
    mif.MemRData = 32'h0;
    #1;

    // ---- Reset, two stores, reset again ----
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_memreq", 32'(mif.MemReq), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    store(32'h60, 32'd7);
    store(32'h218, 32'd1024);
    MemWrite = 1'b0;
    #1;
    chk("t1_memreq", 32'(mif.MemReq), 32'd1);
    chk("t1_memadr", mif.MemAdr, 32'h60);
    chk("t1_memwdata", mif.MemWData, 32'd7);
    chk("t1_level", 32'(Level), 32'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("t1_rst_level", 32'(Level), 32'd0);
    chk("t1_rst_memreq", 32'(mif.MemReq), 32'd0);

    // ---- Fill to DEPTH, stall on the fifth store ----
    for (int i = 0; i < 4; i++) begin
      store(32'(4 * i), 32'h10 + 32'(i));
    end
    MemWrite = 1'b1;
    DataAdr = 32'h10;
    WriteData = 32'h55;
    #1;
    chk("t2_full_level", 32'(Level), 32'd4);
    chk("t2_full_stall", 32'(Stall), 32'd1);
    mif.MemAck = 1'b1;
    #1;
    chk("t2_no_bypass_stall", 32'(Stall), 32'd1);
    base = log_adr.size();
    cyc();
    mif.MemAck = 1'b0;
    #1;
    chk("t2_after_ack_stall", 32'(Stall), 32'd0);
    chk("t2_after_ack_level", 32'(Level), 32'd3);
    chk("t2_first_drained", log_adr[base], 32'h0);
    cyc();
    MemWrite = 1'b0;
    #1;
    chk("t2_refill_level", 32'(Level), 32'd4);
    chk("t2_head_adr", mif.MemAdr, 32'h4);
    chk("t2_head_data", mif.MemWData, 32'h11);
    base = log_adr.size();
    mif.MemAck = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    mif.MemAck = 1'b0;
    #1;
    chk("t2_drain_count", 32'(log_adr.size() - base), 32'd4);
    chk("t2_drain_adr0", log_adr[base], 32'h4);
    chk("t2_drain_adr3", log_adr[base + 3], 32'h10);
    chk("t2_drain_dat2", log_dat[base + 2], 32'h13);
    chk("t2_drain_dat3", log_dat[base + 3], 32'h55);
    chk("t2_empty_level", 32'(Level), 32'd0);

    // ---- Load forwarding, youngest match, word granularity ----
    store(32'h64, 32'd1);
    store(32'h64, 32'd2);
    MemWrite = 1'b0;
    mif.MemRData = 32'hDEAD;
    DataAdr = 32'h64;
    #1;
    chk("t3_fwd_64", ReadData, 32'd2);
    DataAdr = 32'h66;
    #1;
    chk("t3_fwd_66", ReadData, 32'd2);
    DataAdr = 32'h68;
    #1;
    chk("t3_miss_68", ReadData, 32'hDEAD);
    DataAdr = 32'h64;
    mif.MemAck = 1'b1;
    #1;
    chk("t3_fwd_while_pop", ReadData, 32'd2);
    cyc();
    chk("t3_fwd_after_pop", ReadData, 32'd2);
    cyc();
    chk("t3_miss_after_drain", ReadData, 32'hDEAD);

    // ---- Zero-wait drain: one entry per cycle, Level stays <= 1 ----
    base = log_adr.size();
    for (int i = 0; i < 8; i++) begin
      MemWrite = 1'b1;
      DataAdr = 32'h100 + 32'(4 * i);
      WriteData = 32'(i);
      #1;
      chk("t4_no_stall", 32'(Stall), 32'd0);
      chk("t4_level_le1", 32'(Level <= 3'd1), 32'd1);
      cyc();
    end
    MemWrite = 1'b0;
    cyc();
    mif.MemAck = 1'b0;
    #1;
    chk("t4_drain_count", 32'(log_adr.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_dat", log_dat[base + i], 32'(i));
      chk("t4_drain_adr", log_adr[base + i], 32'h100 + 32'(4 * i));
    end
    chk("t4_final_level", 32'(Level), 32'd0);

    // ---- Pointer wrap with concurrent push/pop ----
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    store(32'h200, 32'hA0);
    store(32'h204, 32'hA1);
    store(32'h208, 32'hA2);
    base = log_adr.size();
    mif.MemAck = 1'b1;
    for (int i = 0; i < 10; i++) begin
      MemWrite = 1'b1;
      DataAdr = (i == 9) ? 32'h22C : 32'h20C + 32'(4 * i);
      WriteData = 32'hB0 + 32'(i);
      #1;
      chk("t5_level_steady", 32'(Level), 32'd3);
      cyc();
    end
    MemWrite = 1'b0;
    mif.MemAck = 1'b0;
    #1;
    chk("t5_pop_count", 32'(log_adr.size() - base), 32'd10);
    chk("t5_order0", log_dat[base], 32'hA0);
    chk("t5_order2", log_dat[base + 2], 32'hA2);
    chk("t5_order3", log_dat[base + 3], 32'hB0);
    chk("t5_order9", log_dat[base + 9], 32'hB6);
    chk("t5_order9_adr", log_adr[base + 9], 32'h224);
    chk("t5_head_data", mif.MemWData, 32'hB7);
    mif.MemRData = 32'h1234;
    DataAdr = 32'h22C;
    #1;
    chk("t5_fwd_straddle", ReadData, 32'hB9);

    // ---- Reset mid-handshake ----
    chk("t6_pre_level", 32'(Level), 32'd3);
    chk("t6_pre_memreq", 32'(mif.MemReq), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mif.MemRData = 32'hBEEF;
    #1;
    chk("t6_memreq", 32'(mif.MemReq), 32'd0);
    chk("t6_level", 32'(Level), 32'd0);
    chk("t6_load_miss", ReadData, 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
